// File: rtl/dna_access_arbiter_if.sv
// Response channel between the DNA arbiter and its requesters.
interface dna_access_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [95:0]        rsp_data;
  logic               rsp_err;

  // Arbiter side: sources responses and grants.
  modport master (
    input  req,
    input  rsp_ready,
    output gnt,
    output rsp_valid,
    output rsp_id,
    output rsp_data,
    output rsp_err
  );

  // Requester side.
  modport slave (
    output req,
    output rsp_ready,
    input  gnt,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_data,
    input  rsp_err
  );
endinterface

// File: rtl/dna_access_arbiter.sv
// Sequences the device-DNA reader and shares the cached value among
// NUM_REQ requesters over one round-robin valid/ready response channel.
module dna_access_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DNA_BITS       = 57,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  output logic                 dna_areset,
  input  logic                 dna_read_done,
  input  logic [95:0]          dna_value,
  input  logic                 refresh,
  dna_access_arbiter_if.master rsp,
  output logic                 dna_valid,
  output logic                 dna_err,
  output logic                 busy
);

  localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned IDX_W   = ID_W + 1;
  localparam logic [95:0] DNA_MASK = (96'(1) << DNA_BITS) - 96'(1);

  // Elaboration-time parameter sanity.
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("dna_access_arbiter: NUM_REQ must be 2..16");
  end
  if (RST_CYCLES < 2) begin : g_bad_rst_cycles
    $error("dna_access_arbiter: RST_CYCLES must be >= 2");
  end
  if (DNA_BITS < 1 || DNA_BITS > 96) begin : g_bad_dna_bits
    $error("dna_access_arbiter: DNA_BITS must be 1..96");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("dna_access_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [95:0]       cache_q, cache_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              pend_q, pend_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [95:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              dna_valid_d, dna_err_d, dna_areset_d, busy_d;

  logic              handshake_c;
  logic              sel_found_c;
  logic [ID_W-1:0]   sel_id_c;
  logic [IDX_W-1:0]  sel_idx_c;
  logic [NUM_REQ-1:0] gnt_c;

  assign handshake_c = rsp_valid_q & rsp.rsp_ready;

  // Round-robin pick: first set request at rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  always_comb begin
    sel_found_c = 1'b0;
    sel_id_c    = '0;
    sel_idx_c   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sel_idx_c = IDX_W'(rr_ptr_q) + IDX_W'(k);
      if (sel_idx_c >= IDX_W'(NUM_REQ)) begin
        sel_idx_c = sel_idx_c - IDX_W'(NUM_REQ);
      end
      if (!sel_found_c && rsp.req[sel_idx_c[ID_W-1:0]]) begin
        sel_found_c = 1'b1;
        sel_id_c    = sel_idx_c[ID_W-1:0];
      end
    end
  end

  // Next-state and next-output logic for the read sequencer and response channel.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cache_d     = cache_q;
    rr_ptr_d    = rr_ptr_q;
    pend_d      = pend_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    dna_valid_d = dna_valid;
    dna_err_d   = dna_err;

    case (state_q)
      ST_RST: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT: begin
        if (dna_read_done) begin
          cache_d     = dna_value & DNA_MASK;
          dna_valid_d = 1'b1;
          dna_err_d   = 1'b0;
          state_d     = ST_SERVE;
          cnt_d       = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          dna_valid_d = 1'b0;
          dna_err_d   = 1'b1;
          state_d     = ST_SERVE;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SERVE: begin
        if (rsp_valid_q) begin
          // A refresh arriving while a response is outstanding waits for the handshake.
          if (refresh) begin
            pend_d = 1'b1;
          end
          if (handshake_c) begin
            rsp_valid_d = 1'b0;
            rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
          end
        end else if (refresh || pend_q) begin
          state_d     = ST_RST;
          cnt_d       = '0;
          pend_d      = 1'b0;
          dna_valid_d = 1'b0;
        end else if (sel_found_c) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = sel_id_c;
          rsp_data_d  = dna_err ? '0 : cache_q;
          rsp_err_d   = dna_err;
        end
      end

      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
    endcase

    dna_areset_d = (state_d == ST_RST);
    busy_d       = (state_d != ST_SERVE);
  end

  // State and output registers; async reset restarts the read from RST.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_RST;
      cnt_q       <= '0;
      cache_q     <= '0;
      rr_ptr_q    <= '0;
      pend_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      dna_valid   <= 1'b0;
      dna_err     <= 1'b0;
      dna_areset  <= 1'b1;
      busy        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cache_q     <= cache_d;
      rr_ptr_q    <= rr_ptr_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      dna_valid   <= dna_valid_d;
      dna_err     <= dna_err_d;
      dna_areset  <= dna_areset_d;
      busy        <= busy_d;
    end
  end

  // One-hot grant marks the accepting requester during the handshake cycle.
  always_comb begin
    gnt_c = '0;
    if (handshake_c) begin
      gnt_c[rsp_id_q] = 1'b1;
    end
  end

  assign rsp.gnt       = gnt_c;
  assign rsp.rsp_valid = rsp_valid_q;
  assign rsp.rsp_id    = rsp_id_q;
  assign rsp.rsp_data  = rsp_data_q;
  assign rsp.rsp_err   = rsp_err_q;

endmodule
